// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: NOP encoding, fetch FSM states, IF/ID entry layout.
// IF/ID widths track the 28-bit instruction memory and 32-bit instruction word.
package riscv_pkg;

  localparam int IF_A_WIDTH = 28;
  localparam int IF_I_WIDTH = 32;

  localparam logic [IF_I_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [IF_I_WIDTH-1:0] instr;
    logic [IF_A_WIDTH-1:0] pc;
    logic [IF_A_WIDTH-1:0] pc_plus4;
    logic                  misaligned;
  } if_id_t;

endpackage

// File: rtl/pc_reg.sv
// Program counter: redirect beats advance, advance steps by 4 modulo 2^A_WIDTH.
// One-cycle update; holds whenever neither redirect nor advance is asserted.
module pc_reg #(
  parameter int                  A_WIDTH  = 28,
  parameter logic [A_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  input  logic               advance,
  output logic [A_WIDTH-1:0] pc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (advance) begin
      pc <= pc + A_WIDTH'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register; zero-latency imem, entry valid 1 cycle after fetch.
// Stalls (pc and entry hold) while out_valid & ~out_ready; redirect flushes and overrides.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int                 A_WIDTH   = IF_A_WIDTH,
  parameter int                 I_WIDTH   = IF_I_WIDTH,
  parameter logic [A_WIDTH-1:0] RESET_PC  = '0,
  parameter bit                 BYTE_SWAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [A_WIDTH-1:0] imem_addr,
  input  logic [I_WIDTH-1:0] imem_rd,
  input  logic               redirect_valid,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [I_WIDTH-1:0] out_instr,
  output logic [A_WIDTH-1:0] out_pc,
  output logic [A_WIDTH-1:0] out_pc_plus4,
  output logic               out_misaligned
);

  localparam int NBYTES = I_WIDTH / 8;

  fetch_state_t             state_q, state_d;
  if_id_t                   ent_q, ent_d;
  logic                     vld_q;
  logic [A_WIDTH-1:0]       pc;
  logic                     load;
  logic                     misaligned_pc;
  logic [I_WIDTH-1:0]       swapped;

  assign misaligned_pc = (pc[1:0] != 2'b00);
  assign load          = (state_q == RUN) && !redirect_valid && (!vld_q || out_ready);

  // A misaligned target traps without advancing so the faulting PC stays visible.
  pc_reg #(
    .A_WIDTH  (A_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .advance        (load && !misaligned_pc),
    .pc             (pc)
  );

  assign imem_addr = pc;

  // Memory returns the byte at pc in the MSBs; decode wants it in [7:0].
  always_comb begin
    swapped = imem_rd;
    if (BYTE_SWAP) begin
      for (int b = 0; b < NBYTES; b++) begin
        swapped[8*b +: 8] = imem_rd[8*(NBYTES-1-b) +: 8];
      end
    end
  end

  always_comb begin
    ent_d            = ent_q;
    ent_d.pc         = pc;
    ent_d.pc_plus4   = pc + A_WIDTH'(4);
    ent_d.misaligned = misaligned_pc;
    ent_d.instr      = misaligned_pc ? NOP_INSTR : swapped;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = RUN;
    end else if (load && misaligned_pc) begin
      state_d = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      ent_q <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, misaligned: 1'b0};
    end else if (redirect_valid) begin
      vld_q <= 1'b0;
    end else if (load) begin
      vld_q <= 1'b1;
      ent_q <= ent_d;
    end else if (vld_q && out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid      = vld_q;
  assign out_instr      = ent_q.instr;
  assign out_pc         = ent_q.pc;
  assign out_pc_plus4   = ent_q.pc_plus4;
  assign out_misaligned = ent_q.misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + random bench for fetch_stage against a cycle-level transaction model.
module tb_fetch_stage;
  import riscv_pkg::*;

  localparam int              AW      = 28;
  localparam logic [AW-1:0]   WRAP_PC = 28'hFFF_FFFC;
  localparam logic [31:0]     NOP     = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] imem_addr, redirect_pc, out_pc, out_pc_plus4;
  logic [31:0]   imem_rd, out_instr;
  logic          redirect_valid = 1'b0, out_ready = 1'b1, out_valid, out_misaligned;

  logic [AW-1:0] imem_addr2, out_pc2, out_pc_plus4_2;
  logic [AW-1:0] redirect_pc2 = '0;
  logic [31:0]   imem_rd2, out_instr2;
  logic          redirect_valid2 = 1'b0, out_ready2 = 1'b1, out_valid2, out_misaligned2;

  logic [7:0]    mem [int];
  int            errors = 0;
  int            checks = 0;

  fetch_stage #(.A_WIDTH(AW), .I_WIDTH(32), .RESET_PC('0), .BYTE_SWAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4), .out_misaligned(out_misaligned)
  );

  fetch_stage #(.A_WIDTH(AW), .I_WIDTH(32), .RESET_PC(WRAP_PC), .BYTE_SWAP(1'b1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr2), .imem_rd(imem_rd2),
    .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc(out_pc2), .out_pc_plus4(out_pc_plus4_2), .out_misaligned(out_misaligned2)
  );

  function automatic logic [7:0] mbyte(logic [AW-1:0] a);
    int k;
    k = int'(a);
    if (mem.exists(k)) return mem[k];
    return a[7:0] ^ 8'h5a;
  endfunction

  // Memory port: byte at the address sits in the MSBs.
  function automatic logic [31:0] rd_word(logic [AW-1:0] a);
    return {mbyte(a), mbyte(a + AW'(1)), mbyte(a + AW'(2)), mbyte(a + AW'(3))};
  endfunction

  // What decode should see: byte at the PC in [7:0].
  function automatic logic [31:0] le_word(logic [AW-1:0] a);
    return {mbyte(a + AW'(3)), mbyte(a + AW'(2)), mbyte(a + AW'(1)), mbyte(a)};
  endfunction

  always_comb imem_rd  = rd_word(imem_addr);
  always_comb imem_rd2 = rd_word(imem_addr2);

  task automatic store_insn(input int addr, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[addr + i] = w[8*i +: 8];
  endtask

  // Reference model: the fetch stream and the single IF/ID slot.
  logic [AW-1:0] m_pc, m_opc, m_pc4;
  logic [31:0]   m_instr;
  logic          m_vld, m_mis, m_halt;

  task automatic model_reset();
    m_pc = '0; m_halt = 1'b0; m_vld = 1'b0;
    m_instr = NOP; m_opc = '0; m_pc4 = '0; m_mis = 1'b0;
  endtask

  task automatic model_step();
    if (redirect_valid) begin
      m_vld = 1'b0; m_pc = redirect_pc; m_halt = 1'b0;
    end else if (!m_halt && (!m_vld || out_ready)) begin
      m_vld = 1'b1; m_opc = m_pc; m_pc4 = m_pc + AW'(4);
      if (m_pc % 4 != 0) begin
        m_instr = NOP; m_mis = 1'b1; m_halt = 1'b1;
      end else begin
        m_instr = le_word(m_pc); m_mis = 1'b0; m_pc = m_pc + AW'(4);
      end
    end else if (m_vld && out_ready) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("m_valid", 64'(out_valid), 64'(m_vld));
    chk("m_addr", 64'(imem_addr), 64'(m_pc));
    chk("m_instr", 64'(out_instr), 64'(m_instr));
    chk("m_pc", 64'(out_pc), 64'(m_opc));
    chk("m_pc4", 64'(out_pc_plus4), 64'(m_pc4));
    chk("m_mis", 64'(out_misaligned), 64'(m_mis));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    store_insn(0, 32'h0050_0093);
    store_insn(4, 32'h0010_0113);
    store_insn(8, 32'h0020_81B3);
    redirect_pc = '0;
    model_reset();

    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'(NOP));
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_pc4", 64'(out_pc_plus4), 64'd0);
    chk("rst_mis", 64'(out_misaligned), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wrap_addr", 64'(imem_addr2), 64'(WRAP_PC));
    @(negedge clk);
    rst_n = 1'b1;

    tick();
    chk("c1_valid", 64'(out_valid), 64'd1);
    chk("c1_pc", 64'(out_pc), 64'h0);
    chk("c1_instr", 64'(out_instr), 64'h0050_0093);
    chk("c1_pc4", 64'(out_pc_plus4), 64'h4);
    chk("wrap_pc", 64'(out_pc2), 64'hFFF_FFFC);
    chk("wrap_pc4", 64'(out_pc_plus4_2), 64'h0);
    tick();
    chk("c2_pc", 64'(out_pc), 64'h4);
    chk("c2_instr", 64'(out_instr), 64'h0010_0113);
    chk("wrap_next_pc", 64'(out_pc2), 64'h0);
    chk("wrap_next_pc4", 64'(out_pc_plus4_2), 64'h4);

    out_ready = 1'b0;
    repeat (3) begin
      tick();
      chk("stall_pc", 64'(out_pc), 64'h4);
      chk("stall_instr", 64'(out_instr), 64'h0010_0113);
      chk("stall_addr", 64'(imem_addr), 64'h8);
    end
    out_ready = 1'b1;
    tick();
    chk("resume_pc", 64'(out_pc), 64'h8);
    chk("resume_instr", 64'(out_instr), 64'h0020_81B3);
    chk("resume_pc4", 64'(out_pc_plus4), 64'hC);

    redirect_valid = 1'b1; redirect_pc = AW'('h100);
    tick();
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_addr", 64'(imem_addr), 64'h100);
    redirect_valid = 1'b0;
    tick();
    chk("target_valid", 64'(out_valid), 64'd1);
    chk("target_pc", 64'(out_pc), 64'h100);

    redirect_valid = 1'b1; redirect_pc = AW'('h102);
    tick();
    chk("mis_flush", 64'(out_valid), 64'd0);
    redirect_valid = 1'b0;
    tick();
    chk("mis_valid", 64'(out_valid), 64'd1);
    chk("mis_flag", 64'(out_misaligned), 64'd1);
    chk("mis_instr", 64'(out_instr), 64'(NOP));
    chk("mis_pc", 64'(out_pc), 64'h102);
    repeat (2) begin
      tick();
      chk("halt_valid", 64'(out_valid), 64'd0);
      chk("halt_addr", 64'(imem_addr), 64'h102);
    end
    redirect_valid = 1'b1; redirect_pc = AW'('h200);
    tick();
    redirect_valid = 1'b0;
    tick();
    chk("recover_pc", 64'(out_pc), 64'h200);
    chk("recover_mis", 64'(out_misaligned), 64'd0);
    chk("recover_valid", 64'(out_valid), 64'd1);

    repeat (400) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc = (($urandom_range(0, 1) == 0) ? AW'(0) : AW'('hFFF_FF00))
                      + AW'($urandom_range(0, 60) * 4)
                      + (($urandom_range(0, 4) == 0) ? AW'($urandom_range(1, 3)) : AW'(0));
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end

    redirect_valid = 1'b1; redirect_pc = AW'('h300); out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("pre_arst_valid", 64'(out_valid), 64'd1);
    chk("pre_arst_pc", 64'(out_pc), 64'h300);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_addr", 64'(imem_addr), 64'd0);
    chk("arst_instr", 64'(out_instr), 64'(NOP));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_arst_pc", 64'(out_pc), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
